// File: rtl/handshake_constant_seq.sv
// ---------------------------------------------------------------------------
// handshake_constant_seq
//
// Emits one constant token for every accepted control token. The token value
// comes from CONST_TABLE. In MODE 1 the table index steps through
// 0..DEPTH-1 and wraps. In MODE 0 the index stays at entry 0.
// The output is fully registered. It uses a main register plus a one-entry
// skid register, so ctrl_ready and the outs signals never depend
// combinationally on any input.
//
// Handshake: a transfer happens on a rising clk edge when the sender's
// valid and the receiver's ready are both 1 during that cycle. A valid
// token is held unchanged until the receiver takes it. ctrl_ready does
// not depend on ctrl_valid.
//
// Ports:
//   clk         single clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   ctrl_valid  control token offered (no payload)
//   ctrl_ready  block accepts a control token this cycle
//   outs        constant token data
//   outs_valid  outs holds a valid token
//   outs_ready  downstream consumes the token this cycle
//   seq_idx     table index the next accepted control token will use
// ---------------------------------------------------------------------------
module handshake_constant_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MODE       = 1,
    parameter logic [DEPTH*DATA_WIDTH-1:0] CONST_TABLE = {32'h4, 32'h3, 32'h2, 32'h1},
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [IDX_W-1:0]      seq_idx
);

    logic                  r_ctrl_ready;
    logic                  r_outs_valid;
    logic [DATA_WIDTH-1:0] r_outs;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [IDX_W-1:0]      r_seq_idx;

    logic                  w_accept;
    logic                  w_main_free;
    logic                  w_skid_valid_nxt;
    logic [DATA_WIDTH-1:0] w_token;

    assign w_accept    = ctrl_valid & r_ctrl_ready;
    assign w_main_free = ~r_outs_valid | outs_ready;

    // Table lookup. In MODE 0 the index never leaves 0, so entry 0 is used.
    always_comb begin
        w_token = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_seq_idx == IDX_W'(i)) begin
                w_token = CONST_TABLE[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The skid fills only when the main register is stalled and a token
    // arrives. It drains whenever the main register frees up.
    always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        if (w_main_free) begin
            w_skid_valid_nxt = 1'b0;
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl_ready <= 1'b0;
            r_outs_valid <= 1'b0;
            r_outs       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            // Registered copy of ~skid_valid. It rises on the first edge
            // after reset release.
            r_ctrl_ready <= ~w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_main_free) begin
                // While the skid is full, ctrl_ready is 0. No accept can
                // compete with the skid-to-main move.
                if (r_skid_valid) begin
                    r_outs       <= r_skid_data;
                    r_outs_valid <= 1'b1;
                end else if (w_accept) begin
                    r_outs       <= w_token;
                    r_outs_valid <= 1'b1;
                end else begin
                    r_outs_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_data <= w_token;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seq_idx <= '0;
        end else if (MODE == 1 && DEPTH > 1 && w_accept) begin
            if (r_seq_idx == IDX_W'(DEPTH - 1)) begin
                r_seq_idx <= '0;
            end else begin
                r_seq_idx <= r_seq_idx + IDX_W'(1);
            end
        end
    end

    assign ctrl_ready = r_ctrl_ready;
    assign outs       = r_outs;
    assign outs_valid = r_outs_valid;
    assign seq_idx    = r_seq_idx;

endmodule

// File: tb/tb_handshake_constant_seq.sv
// ---------------------------------------------------------------------------
// tb_handshake_constant_seq
//
// Three instances share clk, rst, ctrl_valid and outs_ready:
//   inst 0: defaults (MODE 1, DEPTH 4, 32-bit, entries 1..4)
//   inst 1: MODE 0 (always entry 0 = 1)
//   inst 2: DEPTH 1, 33-bit, single entry 33'h0A10EC2AD
// The reference model treats each instance as a 2-token buffer. Token k
// (0-based since reset) has a value that follows directly from the table.
// ---------------------------------------------------------------------------
module tb_handshake_constant_seq;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic ctrl_valid = 1'b0;
    logic outs_ready = 1'b0;

    always #5 clk = ~clk;

    logic        a_rdy, a_vld;
    logic [31:0] a_outs;
    logic [1:0]  a_idx;
    logic        b_rdy, b_vld;
    logic [31:0] b_outs;
    logic [1:0]  b_idx;
    logic        c_rdy, c_vld;
    logic [32:0] c_outs;
    logic [0:0]  c_idx;

    handshake_constant_seq u_a (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(a_rdy),
        .outs(a_outs), .outs_valid(a_vld), .outs_ready(outs_ready), .seq_idx(a_idx)
    );

    handshake_constant_seq #(.MODE(0)) u_b (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(b_rdy),
        .outs(b_outs), .outs_valid(b_vld), .outs_ready(outs_ready), .seq_idx(b_idx)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(33), .DEPTH(1), .MODE(1), .CONST_TABLE(33'h0A10EC2AD)
    ) u_c (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(c_rdy),
        .outs(c_outs), .outs_valid(c_vld), .outs_ready(outs_ready), .seq_idx(c_idx)
    );

    logic [32:0] d_outs [3];
    logic        d_vld  [3];
    logic        d_rdy  [3];
    logic [7:0]  d_idx  [3];

    always_comb begin
        d_outs[0] = {1'b0, a_outs};
        d_outs[1] = {1'b0, b_outs};
        d_outs[2] = c_outs;
        d_vld[0]  = a_vld;
        d_vld[1]  = b_vld;
        d_vld[2]  = c_vld;
        d_rdy[0]  = a_rdy;
        d_rdy[1]  = b_rdy;
        d_rdy[2]  = c_rdy;
        d_idx[0]  = {6'b0, a_idx};
        d_idx[1]  = {6'b0, b_idx};
        d_idx[2]  = {7'b0, c_idx};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_acc  [3];   // tokens accepted since reset
    int m_emit [3];   // tokens consumed downstream since reset
    bit m_rdy_en = 1'b0;

    function automatic logic [32:0] tok(input int inst, input int k);
        case (inst)
            0:       tok = 33'((k % 4) + 1);
            1:       tok = 33'd1;
            default: tok = 33'h0A10EC2AD;
        endcase
    endfunction

    function automatic logic [7:0] exp_idx(input int inst, input int acc);
        exp_idx = (inst == 0) ? 8'(acc % 4) : 8'd0;
    endfunction

    always begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_acc[i]  = 0;
                m_emit[i] = 0;
            end else begin
                int  sz;
                bit  pop, push;
                sz   = m_acc[i] - m_emit[i];
                pop  = (sz > 0) && outs_ready;
                push = ctrl_valid && m_rdy_en && (sz < 2);
                if (pop)  m_emit[i]++;
                if (push) m_acc[i]++;
            end
        end
        m_rdy_en = rst;
        #1;
        for (int i = 0; i < 3; i++) begin
            int sz;
            sz = m_acc[i] - m_emit[i];
            check($sformatf("ctrl_ready[%0d]", i), 33'(d_rdy[i]), 33'(m_rdy_en && (sz < 2)));
            check($sformatf("outs_valid[%0d]", i), 33'(d_vld[i]), 33'(sz > 0));
            if (sz > 0)
                check($sformatf("outs[%0d]", i), d_outs[i], tok(i, m_emit[i]));
            check($sformatf("seq_idx[%0d]", i), 33'(d_idx[i]), 33'(exp_idx(i, m_acc[i])));
        end
    end

    // ---------------- driver ----------------
    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        ctrl_valid = 1'b0;
        outs_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] lit [6];
        lit = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2};

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs",  33'(a_outs), 33'd0);
        check("rst_vld",   33'(a_vld),  33'd0);
        check("rst_rdy",   33'(a_rdy),  33'd0);
        check("rst_idx",   33'(a_idx),  33'd0);
        check("rst_c_outs", c_outs,     33'd0);

        // Streaming: outs = 1,2,3,4,1,2 one cycle after each accept
        rst        = 1'b1;
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stream_no_tok_yet", 33'(a_vld), 33'd0);
        check("stream_rdy_up",     33'(a_rdy), 33'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stream_a_%0d", i), 33'(a_outs), 33'(lit[i]));
            check($sformatf("stream_a_vld_%0d", i), 33'(a_vld), 33'd1);
            check($sformatf("stream_b_%0d", i), 33'(b_outs), 33'd1);
            check($sformatf("stream_b_idx_%0d", i), 33'(b_idx), 33'd0);
            check($sformatf("stream_c_%0d", i), c_outs, 33'h0A10EC2AD);
        end

        // Backpressure: main holds 1, skid holds 2, then drain in order
        do_reset();
        ctrl_valid = 1'b1;
        outs_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_main", 33'(a_outs), 33'd1);
        check("bp_rdy0", 33'(a_rdy),  33'd0);
        repeat (2) @(negedge clk);
        check("bp_hold", 33'(a_outs), 33'd1);
        outs_ready = 1'b1;
        ctrl_valid = 1'b0;
        @(negedge clk);
        check("bp_skid_out", 33'(a_outs), 33'd2);
        check("bp_rdy1",     33'(a_rdy),  33'd1);
        @(negedge clk);
        check("bp_drained",  33'(a_vld),  33'd0);

        // Reset with skid full after 3 tokens emitted
        do_reset();
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_pre_outs", 33'(a_outs), 33'd4);
        outs_ready = 1'b0;
        @(negedge clk);
        check("mid_skid_full", 33'(a_rdy), 33'd0);
        check("mid_idx",       33'(a_idx), 33'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_vld",  33'(a_vld),  33'd0);
        check("mid_rst_idx",  33'(a_idx),  33'd0);
        check("mid_rst_outs", 33'(a_outs), 33'd0);
        check("mid_rst_rdy",  33'(a_rdy),  33'd0);
        @(negedge clk);
        rst        = 1'b1;
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_first_tok", 33'(a_outs), 33'd1);
        check("mid_first_vld", 33'(a_vld),  33'd1);

        // Random valid/ready with varying bias and one mid-run reset
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            if (cyc == 5000) begin
                rst = 1'b0;
            end else if (cyc == 5002) begin
                rst = 1'b1;
            end
            ctrl_valid = ($urandom_range(0, 3) < (cyc / 2500) + 1);
            outs_ready = ($urandom_range(0, 3) >= (cyc % 4000) / 1000);
        end

        ctrl_valid = 1'b0;
        outs_ready = 1'b1;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
